// File: rtl/modbus_rtu_master_if.sv
// Bus bundle for the Modbus RTU master: command request, UART TX/RX byte streams, response.
// The master modport is the engine side; the slave modport is the SoC/UART side.
interface modbus_rtu_master_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [7:0]  i_cmd_slave;
  logic [7:0]  i_cmd_func;
  logic [15:0] i_cmd_addr;
  logic [15:0] i_cmd_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rsp_valid;
  logic [2:0]  o_rsp_status;
  logic [15:0] o_rsp_data;
  logic        o_busy;

  modport master (
    input  i_cmd_valid, i_cmd_slave, i_cmd_func, i_cmd_addr, i_cmd_data,
    input  i_tx_ready, i_rx_data, i_rx_valid,
    output o_cmd_ready, o_tx_data, o_tx_valid, o_rsp_valid, o_rsp_status, o_rsp_data, o_busy
  );

  modport slave (
    output i_cmd_valid, i_cmd_slave, i_cmd_func, i_cmd_addr, i_cmd_data,
    output i_tx_ready, i_rx_data, i_rx_valid,
    input  o_cmd_ready, o_tx_data, o_tx_valid, o_rsp_valid, o_rsp_status, o_rsp_data, o_busy
  );
endinterface

// File: rtl/modbus_rtu_master.sv
// Modbus RTU master: sends one 0x03/0x06 request frame with CRC-16 and validates the reply.
// One command in flight; the result is a single o_rsp_valid pulse with a status code.
module modbus_rtu_master #(
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input logic i_clk,
  input logic i_rst_n,
  modbus_rtu_master_if.master bus
);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [7:0] FN_READ  = 8'h03;
  localparam logic [7:0] FN_WRITE = 8'h06;
  localparam logic [2:0] RS_OK = 3'd0, RS_TMO = 3'd1, RS_CRC = 3'd2;
  localparam logic [2:0] RS_EXC = 3'd3, RS_MIS = 3'd4, RS_ILL = 3'd5;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_TX = 2'd1, ST_RX = 2'd2, ST_DONE = 2'd3} state_t;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] din);
    logic [15:0] c;
    c = crc ^ {8'h00, din};
    for (int i = 0; i < 32'sd8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  state_t        state_r, state_nxt_s;
  logic [7:0]    slave_r, func_r, tx_data_r, tx_next_s;
  logic [15:0]   addr_r, data_r, crc_r, word_r, rsp_data_r, fin_data_s, crc_tx_s, crc_rx_s;
  logic [2:0]    tx_idx_r, rsp_status_r, fin_status_s;
  logic [3:0]    rx_cnt_r, exp_len_r;
  logic [TW-1:0] tmo_r;
  logic          exc_r, mismatch_r, tx_valid_r, rsp_valid_r, cmd_ready_r, busy_r;
  logic          cmd_acc_s, cmd_illegal_s, tx_hs_s, tx_last_s, rx_byte_s, rx_last_s;
  logic          tmo_hit_s, byte_bad_s, data_byte_s;

  assign cmd_acc_s     = bus.i_cmd_valid && cmd_ready_r;
  assign cmd_illegal_s = ((bus.i_cmd_func != FN_READ) && (bus.i_cmd_func != FN_WRITE)) ||
                         ((bus.i_cmd_slave == 8'h00) && (bus.i_cmd_func == FN_READ));
  assign tx_hs_s       = tx_valid_r && bus.i_tx_ready;
  assign tx_last_s     = tx_hs_s && (tx_idx_r == 3'd7);
  assign rx_byte_s     = (state_r == ST_RX) && bus.i_rx_valid;
  assign rx_last_s     = rx_byte_s && (rx_cnt_r >= 4'd2) && (rx_cnt_r == exp_len_r - 4'd1);
  assign tmo_hit_s     = (state_r == ST_RX) && !bus.i_rx_valid && (tmo_r == TMO_LAST);
  // The two CRC bytes at the end of a reply never enter the data word.
  assign data_byte_s   = (rx_cnt_r < 4'd2) || (rx_cnt_r < exp_len_r - 4'd2);
  assign crc_tx_s      = crc16_byte(crc_r, tx_data_r);
  assign crc_rx_s      = crc16_byte(crc_r, bus.i_rx_data);

  assign bus.o_cmd_ready  = cmd_ready_r;
  assign bus.o_busy       = busy_r;
  assign bus.o_tx_data    = tx_data_r;
  assign bus.o_tx_valid   = tx_valid_r;
  assign bus.o_rsp_valid  = rsp_valid_r;
  assign bus.o_rsp_status = rsp_status_r;
  assign bus.o_rsp_data   = rsp_data_r;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (cmd_acc_s) state_nxt_s = cmd_illegal_s ? ST_DONE : ST_TX;
               else           state_nxt_s = ST_IDLE;
      ST_TX:   if (tx_last_s) state_nxt_s = (slave_r == 8'h00) ? ST_DONE : ST_RX;
               else           state_nxt_s = ST_TX;
      ST_RX:   if (rx_last_s || tmo_hit_s) state_nxt_s = ST_DONE;
               else                        state_nxt_s = ST_RX;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Request byte following the one just handed to the UART
  always_comb begin
    tx_next_s = 8'h00;
    case (tx_idx_r)
      3'd0:    tx_next_s = func_r;
      3'd1:    tx_next_s = addr_r[15:8];
      3'd2:    tx_next_s = addr_r[7:0];
      3'd3:    tx_next_s = (func_r == FN_READ) ? 8'h00 : data_r[15:8];
      3'd4:    tx_next_s = (func_r == FN_READ) ? 8'h01 : data_r[7:0];
      3'd5:    tx_next_s = crc_tx_s[7:0];
      3'd6:    tx_next_s = crc_r[15:8];
      default: tx_next_s = 8'h00;
    endcase
  end

  // Per-byte reply consistency check; exception replies carry no echo fields
  always_comb begin
    byte_bad_s = 1'b0;
    case (rx_cnt_r)
      4'd0:    byte_bad_s = (bus.i_rx_data != slave_r);
      4'd1:    byte_bad_s = (bus.i_rx_data[6:0] != func_r[6:0]);
      4'd2:    if (exc_r)                  byte_bad_s = 1'b0;
               else if (func_r == FN_READ) byte_bad_s = (bus.i_rx_data != 8'h02);
               else                        byte_bad_s = (bus.i_rx_data != addr_r[15:8]);
      4'd3:    byte_bad_s = !exc_r && (func_r == FN_WRITE) && (bus.i_rx_data != addr_r[7:0]);
      4'd4:    byte_bad_s = !exc_r && (func_r == FN_WRITE) && (bus.i_rx_data != data_r[15:8]);
      4'd5:    byte_bad_s = !exc_r && (func_r == FN_WRITE) && (bus.i_rx_data != data_r[7:0]);
      default: byte_bad_s = 1'b0;
    endcase
  end

  // Final status with priority CRC > mismatch > exception > OK
  always_comb begin
    fin_status_s = RS_OK;
    fin_data_s   = word_r;
    if (crc_rx_s != 16'h0000) begin
      fin_status_s = RS_CRC;
      fin_data_s   = 16'h0000;
    end else if (mismatch_r || byte_bad_s) begin
      fin_status_s = RS_MIS;
      fin_data_s   = 16'h0000;
    end else if (exc_r) begin
      fin_status_s = RS_EXC;
      fin_data_s   = {8'h00, word_r[7:0]};
    end else begin
      fin_status_s = RS_OK;
      fin_data_s   = word_r;
    end
  end

  // Datapath: command latch, TX serialiser, RX collector, timeout and response outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slave_r <= 8'h00;  func_r <= 8'h00;  addr_r <= 16'h0000;  data_r <= 16'h0000;
      crc_r <= 16'hFFFF; word_r <= 16'h0000;
      tx_idx_r <= 3'd0;  tx_data_r <= 8'h00;  tx_valid_r <= 1'b0;
      rx_cnt_r <= 4'd0;  exp_len_r <= 4'd8;  exc_r <= 1'b0;  mismatch_r <= 1'b0;
      tmo_r <= '0;
      rsp_valid_r <= 1'b0;  rsp_status_r <= RS_OK;  rsp_data_r <= 16'h0000;
      cmd_ready_r <= 1'b1;  busy_r <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      cmd_ready_r <= (state_nxt_s == ST_IDLE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: if (cmd_acc_s) begin
          slave_r  <= bus.i_cmd_slave;
          func_r   <= bus.i_cmd_func;
          addr_r   <= bus.i_cmd_addr;
          data_r   <= bus.i_cmd_data;
          crc_r    <= 16'hFFFF;
          tx_idx_r <= 3'd0;
          if (cmd_illegal_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_status_r <= RS_ILL;
            rsp_data_r   <= 16'h0000;
          end else begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= bus.i_cmd_slave;
          end
        end
        ST_TX: if (tx_hs_s) begin
          tx_idx_r <= tx_idx_r + 3'd1;
          if (tx_idx_r <= 3'd5) crc_r <= crc_tx_s;
          if (tx_idx_r == 3'd7) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            if (slave_r == 8'h00) begin
              rsp_valid_r  <= 1'b1;
              rsp_status_r <= RS_OK;
              rsp_data_r   <= data_r;
            end else begin
              crc_r      <= 16'hFFFF;
              rx_cnt_r   <= 4'd0;
              exp_len_r  <= 4'd8;
              exc_r      <= 1'b0;
              mismatch_r <= 1'b0;
              word_r     <= 16'h0000;
              tmo_r      <= '0;
            end
          end else begin
            tx_data_r <= tx_next_s;
          end
        end
        ST_RX: if (rx_byte_s) begin
          crc_r    <= crc_rx_s;
          rx_cnt_r <= rx_cnt_r + 4'd1;
          tmo_r    <= '0;
          if (byte_bad_s) mismatch_r <= 1'b1;
          if (data_byte_s) word_r <= {word_r[7:0], bus.i_rx_data};
          if (rx_cnt_r == 4'd1) begin
            exc_r     <= bus.i_rx_data[7];
            exp_len_r <= bus.i_rx_data[7] ? 4'd5 : ((func_r == FN_READ) ? 4'd7 : 4'd8);
          end
          if (rx_last_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_status_r <= fin_status_s;
            rsp_data_r   <= fin_data_s;
          end
        end else if (tmo_hit_s) begin
          rsp_valid_r  <= 1'b1;
          rsp_status_r <= RS_TMO;
          rsp_data_r   <= 16'h0000;
        end else begin
          tmo_r <= tmo_r + 1'b1;
        end
        ST_DONE: rsp_valid_r <= 1'b0;
        default: rsp_valid_r <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_modbus_rtu_master.sv
// Scoreboard bench for modbus_rtu_master: directed commands, expected TX bytes and
// responses queued at issue time, checked by a negedge monitor.
module tb_modbus_rtu_master;
  localparam int unsigned T = 40;

  typedef struct { logic [2:0] st; logic [15:0] d; } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic toggle_en = 1'b0;
  int   cyc = 0, chk_cnt = 0, pass_cnt = 0;
  int   rsp_cnt = 0, rsp_cyc = 0, last_tx_cyc = 0, last_rx_cyc = 0;
  logic stall_r = 1'b0;
  logic [7:0] stall_byte_r = 8'h00;
  logic [7:0] tx_exp_q[$];
  logic [7:0] frm[$];
  rsp_t rsp_exp_q[$];

  modbus_rtu_master_if bus();
  modbus_rtu_master #(.TIMEOUT_CYCLES(T)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    chk_cnt++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [15:0] frm_crc();
    logic [15:0] r;
    logic fb;
    r = 16'hFFFF;
    foreach (frm[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = r[0] ^ frm[i][k];
        r  = r >> 1;
        if (fb) r = r ^ 16'hA001;
      end
    end
    return r;
  endfunction

  task automatic add_crc();
    logic [15:0] c;
    c = frm_crc();
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
  endtask

  // Monitor: TX byte order/stability and response scoreboard
  always @(negedge clk) begin
    if (stall_r) begin
      check("tx_hold_valid", bus.o_tx_valid, 1);
      check("tx_hold_data", bus.o_tx_data, stall_byte_r);
    end
    stall_r      <= bus.o_tx_valid && !bus.i_tx_ready;
    stall_byte_r <= bus.o_tx_data;
    if (bus.o_tx_valid && bus.i_tx_ready) begin
      last_tx_cyc <= cyc;
      if (tx_exp_q.size() == 0) fail("tx_unexpected_byte");
      else begin
        check("tx_byte", bus.o_tx_data, tx_exp_q[0]);
        void'(tx_exp_q.pop_front());
      end
    end
    if (bus.i_rx_valid) last_rx_cyc <= cyc;
    if (bus.o_rsp_valid) begin
      rsp_cyc <= cyc;
      rsp_cnt <= rsp_cnt + 1;
      if (rsp_exp_q.size() == 0) fail("rsp_unexpected");
      else begin
        check("rsp_status", bus.o_rsp_status, rsp_exp_q[0].st);
        check("rsp_data", bus.o_rsp_data, rsp_exp_q[0].d);
        void'(rsp_exp_q.pop_front());
      end
    end
  end

  // UART TX ready: held high, or toggled every cycle for backpressure
  initial begin
    bus.i_tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (toggle_en) bus.i_tx_ready = ~bus.i_tx_ready;
      else           bus.i_tx_ready = 1'b1;
    end
  end

  task automatic send_cmd(input logic [7:0] s, input logic [7:0] f, input logic [15:0] a,
                          input logic [15:0] d, output int acc);
    acc = -1;
    @(posedge clk); #1;
    bus.i_cmd_slave = s; bus.i_cmd_func = f; bus.i_cmd_addr = a; bus.i_cmd_data = d;
    bus.i_cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_cmd_ready) begin acc = cyc; break; end
    end
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    if (acc < 0) fail("cmd_accept_timeout");
  endtask

  task automatic send_rx();
    foreach (frm[i]) begin
      @(posedge clk); #1;
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = frm[i];
    end
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic wait_tx_done();
    for (int i = 0; i < 100; i++) begin
      if (tx_exp_q.size() == 0 && !bus.o_tx_valid) return;
      @(negedge clk); #1;
    end
    fail("tx_done_timeout");
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rsp_cnt > n) return;
      @(negedge clk); #1;
    end
    fail("rsp_wait_timeout");
  endtask

  task automatic after_rsp(input logic [2:0] st, input logic [15:0] d);
    @(posedge clk); #1;
    check("ready_after_rsp", bus.o_cmd_ready, 1);
    check("rsp_held_status", bus.o_rsp_status, st);
    check("rsp_held_data", bus.o_rsp_data, d);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", bus.o_cmd_ready, 1);
    check("rst_busy", bus.o_busy, 0);
    check("rst_tx_valid", bus.o_tx_valid, 0);
    check("rst_tx_data", bus.o_tx_data, 0);
    check("rst_rsp_valid", bus.o_rsp_valid, 0);
    check("rst_rsp_status", bus.o_rsp_status, 0);
    check("rst_rsp_data", bus.o_rsp_data, 0);
  endtask

  // Read transaction with a well-formed reply carrying rd
  task automatic read_ok(input logic [15:0] a, input logic [15:0] rd);
    int acc, n;
    frm = '{8'h01, 8'h03, a[15:8], a[7:0], 8'h00, 8'h01};
    add_crc();
    foreach (frm[i]) tx_exp_q.push_back(frm[i]);
    rsp_exp_q.push_back('{3'd0, rd});
    n = rsp_cnt;
    send_cmd(8'h01, 8'h03, a, 16'h0000, acc);
    wait_tx_done();
    frm = '{8'h01, 8'h03, 8'h02, rd[15:8], rd[7:0]};
    add_crc();
    send_rx();
    wait_rsp(n, 50);
    check("rd_rsp_latency", rsp_cyc, last_rx_cyc + 1);
    after_rsp(3'd0, rd);
  endtask

  // Command with a given reply frame in frm_reply order; TX frame is the standard one
  task automatic txn_with_reply(input logic [7:0] f, input logic [15:0] a, input logic [15:0] d,
                                input logic [7:0] rep[$], input logic [2:0] st,
                                input logic [15:0] rd);
    int acc, n;
    frm = '{8'h01, f, a[15:8], a[7:0], (f == 8'h03) ? 8'h00 : d[15:8],
            (f == 8'h03) ? 8'h01 : d[7:0]};
    add_crc();
    foreach (frm[i]) tx_exp_q.push_back(frm[i]);
    rsp_exp_q.push_back('{st, rd});
    n = rsp_cnt;
    send_cmd(8'h01, f, a, d, acc);
    wait_tx_done();
    frm = rep;
    send_rx();
    wait_rsp(n, 50);
    check("reply_rsp_latency", rsp_cyc, last_rx_cyc + 1);
    after_rsp(st, rd);
  endtask

  initial begin
    int acc, n;
    logic [7:0] rep[$];
    bus.i_cmd_valid = 1'b0; bus.i_cmd_slave = 8'h00; bus.i_cmd_func = 8'h00;
    bus.i_cmd_addr = 16'h0000; bus.i_cmd_data = 16'h0000;
    bus.i_rx_valid = 1'b0; bus.i_rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;

    // Read 0x0000: request bytes fixed by hand, reply 0x1234
    tx_exp_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    rsp_exp_q.push_back('{3'd0, 16'h1234});
    n = rsp_cnt;
    send_cmd(8'h01, 8'h03, 16'h0000, 16'h0000, acc);
    check("tx_first_valid", bus.o_tx_valid, 1);
    check("tx_first_byte", bus.o_tx_data, 8'h01);
    check("busy_in_tx", bus.o_busy, 1);
    wait_tx_done();
    frm = '{8'h01, 8'h03, 8'h02, 8'h12, 8'h34};
    add_crc();
    send_rx();
    wait_rsp(n, 50);
    check("rd_rsp_latency", rsp_cyc, last_rx_cyc + 1);
    after_rsp(3'd0, 16'h1234);

    // Write 0x0001 <= 0x0003, correct echo
    tx_exp_q = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
    rsp_exp_q.push_back('{3'd0, 16'h0003});
    n = rsp_cnt;
    send_cmd(8'h01, 8'h06, 16'h0001, 16'h0003, acc);
    wait_tx_done();
    frm = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
    send_rx();
    wait_rsp(n, 50);
    after_rsp(3'd0, 16'h0003);

    // Write echo with wrong data byte but valid CRC -> mismatch
    frm = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h04};
    add_crc();
    rep = frm;
    txn_with_reply(8'h06, 16'h0001, 16'h0003, rep, 3'd4, 16'h0000);

    // Exception reply, then the same with a corrupted CRC byte
    rep = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
    txn_with_reply(8'h03, 16'h0000, 16'h0000, rep, 3'd3, 16'h0002);
    rep = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF2};
    txn_with_reply(8'h03, 16'h0000, 16'h0000, rep, 3'd2, 16'h0000);

    // Backpressured read of 0x0102 with no reply -> timeout
    frm = '{8'h01, 8'h03, 8'h01, 8'h02, 8'h00, 8'h01};
    add_crc();
    foreach (frm[i]) tx_exp_q.push_back(frm[i]);
    rsp_exp_q.push_back('{3'd1, 16'h0000});
    n = rsp_cnt;
    toggle_en = 1'b1;
    send_cmd(8'h01, 8'h03, 16'h0102, 16'h0000, acc);
    wait_tx_done();
    toggle_en = 1'b0;
    wait_rsp(n, T + 50);
    check("tmo_latency_no_rx", rsp_cyc, last_tx_cyc + T + 1);
    after_rsp(3'd1, 16'h0000);

    // Three reply bytes then silence -> timeout counted from the last byte
    tx_exp_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
    rsp_exp_q.push_back('{3'd1, 16'h0000});
    n = rsp_cnt;
    send_cmd(8'h01, 8'h03, 16'h0000, 16'h0000, acc);
    wait_tx_done();
    frm = '{8'h01, 8'h03, 8'h02};
    send_rx();
    wait_rsp(n, T + 50);
    check("tmo_latency_partial", rsp_cyc, last_rx_cyc + T + 1);

    // Illegal function and broadcast read: status 5 next cycle, no TX
    rsp_exp_q.push_back('{3'd5, 16'h0000});
    n = rsp_cnt;
    send_cmd(8'h01, 8'h10, 16'h0000, 16'h0000, acc);
    wait_rsp(n, 10);
    check("illegal_latency", rsp_cyc, acc + 1);
    after_rsp(3'd5, 16'h0000);
    rsp_exp_q.push_back('{3'd5, 16'h0000});
    n = rsp_cnt;
    send_cmd(8'h00, 8'h03, 16'h0000, 16'h0000, acc);
    wait_rsp(n, 10);
    check("bcast_read_latency", rsp_cyc, acc + 1);

    // Broadcast write: full TX, immediate completion, data echoes command
    frm = '{8'h00, 8'h06, 8'h00, 8'h02, 8'hAB, 8'hCD};
    add_crc();
    foreach (frm[i]) tx_exp_q.push_back(frm[i]);
    rsp_exp_q.push_back('{3'd0, 16'hABCD});
    n = rsp_cnt;
    send_cmd(8'h00, 8'h06, 16'h0002, 16'hABCD, acc);
    wait_tx_done();
    wait_rsp(n, 10);
    check("bcast_write_latency", rsp_cyc, last_tx_cyc + 1);
    after_rsp(3'd0, 16'hABCD);

    // Reset while request byte 4 is on the bus: no response, outputs back to reset values
    tx_exp_q = '{8'h01, 8'h03, 8'h00, 8'h05, 8'h00, 8'h01, 8'h00, 8'h00};
    n = rsp_cnt;
    send_cmd(8'h01, 8'h03, 16'h0005, 16'h0000, acc);
    for (int i = 0; i < 20 && tx_exp_q.size() != 4; i++) begin @(negedge clk); #1; end
    check("tx_bytes_before_reset", tx_exp_q.size(), 4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    tx_exp_q.delete();
    #1 check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 check("no_rsp_on_reset", rsp_cnt, n);
    rst_n = 1'b1;
    read_ok(16'h0010, 16'h5678);

    // Stray RX byte while idle must not start anything
    n = rsp_cnt;
    frm = '{8'h01};
    send_rx();
    repeat (T + 5) @(posedge clk);
    #1 check("idle_rx_ignored", rsp_cnt, n);
    check("idle_rx_ready", bus.o_cmd_ready, 1);

    check("tx_queue_drained", tx_exp_q.size(), 0);
    check("rsp_queue_drained", rsp_exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/modbus_rtu_master.md
# modbus_rtu_master

Modbus RTU master transaction engine: accepts one register command (Read Holding Register 0x03, count 1, or Write Single Register 0x06), serialises the request frame with CRC-16 onto a byte stream toward a UART transmitter, then collects and validates the slave's response from a UART receiver byte stream. It is the initiator counterpart of our Modbus slave/register-space controller and lets the SoC poll or configure external Modbus devices over the same UART link.

## Interface
- TIMEOUT_CYCLES, 200000: idle clocks allowed before the first response byte and between response bytes.
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  high in IDLE; command accepted on valid&&ready
- i_cmd_slave  in  8  slave address (0 = broadcast)
- i_cmd_func  in  8  0x03 or 0x06
- i_cmd_addr  in  16  register address
- i_cmd_data  in  16  write data (0x06 only)
- o_tx_data  out  8  request byte
- o_tx_valid  out  1  byte available; held stable until i_tx_ready
- i_tx_ready  in  1  UART TX accepts byte
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe per received byte
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rsp_status  out  3  0 OK, 1 timeout, 2 CRC error, 3 slave exception, 4 frame mismatch, 5 illegal command
- o_rsp_data  out  16  read data (OK/0x03), echoed data (OK/0x06), exception code in [7:0] (status 3), else 0
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, TX, RX, DONE.
- IDLE: on accept, latch command. func not 0x03/0x06, or slave 0 with 0x03 -> DONE, status 5, no TX.
- TX: send 8 bytes: slave, func, addrH, addrL, then 0x00,0x01 (0x03) or dataH,dataL (0x06), then CRC low, CRC high. Byte advances only on o_tx_valid && i_tx_ready.
- CRC-16: init 0xFFFF, reflected poly 0xA001, LSB-first, updated in one cycle per byte (8 unrolled steps). Same function checks RX.
- After last TX byte: broadcast (slave 0, 0x06) -> DONE, status 0, o_rsp_data = i_cmd_data; otherwise RX with CRC re-initialised.
- RX: byte count from 0. Expected length set after byte 1 (func): bit7 set -> 5; 0x03 -> 7; 0x06 -> 8. Final two bytes are CRC (low first); CRC over whole frame must give residue 0x0000.
- Checks (mismatch flag, sticky): byte0 != slave; func[6:0] != command func; 0x03 byte-count byte != 0x02; 0x06 echo bytes 2-5 != sent addr/data.
- Status priority at frame end: CRC error > mismatch > exception > OK.
- Timeout counter cleared on entering RX and on every i_rx_valid; reaching TIMEOUT_CYCLES -> DONE, status 1, partial frame discarded.
- i_rx_valid in IDLE, TX, DONE ignored; bytes beyond expected length never reach RX.
- DONE: o_rsp_valid pulse one cycle, then IDLE.

## Timing
- Reset: o_cmd_ready=1 (IDLE), o_tx_valid=0, o_tx_data=0, o_rsp_valid=0, o_rsp_status=0, o_rsp_data=0, o_busy=0; CRC, counters cleared. Reset mid-frame aborts with no response pulse.
- Accept at cycle N -> o_tx_valid=1 with slave byte at N+1. With i_tx_ready tied high, one byte per cycle, 8 cycles.
- Illegal command accepted at N -> o_rsp_valid at N+1.
- Final RX byte strobe at cycle M -> o_rsp_valid at M+1; o_cmd_ready high at M+2.
- Timeout: o_rsp_valid exactly TIMEOUT_CYCLES+1 cycles after last byte/RX entry.
- o_rsp_status/o_rsp_data held from pulse until next accept.
- i_cmd_valid while busy: not accepted; no queueing.

## Test plan
- Read: slave 0x01, func 0x03, addr 0x0000 -> TX 01 03 00 00 00 01 84 0A; inject 01 03 02 12 34 + correct CRC -> status 0, data 0x1234.
- Write: slave 0x01, func 0x06, addr 0x0001, data 0x0003 -> TX 01 06 00 01 00 03 98 0B; echo same 8 bytes -> status 0, data 0x0003; echo with byte 5 = 0x04 and recomputed CRC -> status 4.
- Exception: read command, inject 01 83 02 C0 F1 -> status 3, data 0x0002; same with CRC byte 0xF2 -> status 2.
- Timeout/backpressure: i_tx_ready toggled every other cycle -> bytes stable, order intact; no RX -> status 1 after TIMEOUT_CYCLES+1; 3 bytes then silence -> status 1.
- Illegal/broadcast: func 0x10 -> status 5 next cycle, no TX; slave 0 func 0x06 -> 8 bytes TX, status 0, no RX wait.
- Reset asserted mid-TX byte 4 -> all outputs at reset values, no o_rsp_valid; next command completes normally.
